vid_fetch: RTL and testbench

//   Display prefetcher directly upstream of the 32K x 8 video RAM port. It walks
//   a frame buffer linearly, issuing one-byte reads (en/addr, data 1 cycle later),
//   and buffers returned bytes in an internal FIFO. The pixel serialiser drains
//   the FIFO over a valid/ready handshake; a per-byte end-of-line flag rides along.

---
 rtl/vid_fetch_if.sv | 29 ++
 rtl/vid_fetch.sv | 152 +++++++++++++++
 tb/tb_vid_fetch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vid_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : vid_fetch_if
// Brief    : RAM read port, pixel stream and frame control for vid_fetch.
// Revision : 1.0
// ============================================================================
interface vid_fetch_if;
   logic        frame_start;
   logic        frame_done;
   logic        ram_busy;
   logic        ram_en;
   logic [14:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_data;
   logic        pix_eol;

   modport master (
      input  frame_start, ram_busy, ram_dout, pix_ready,
      output frame_done, ram_en, ram_addr, pix_valid, pix_data, pix_eol
   );

   modport slave (
      output frame_start, ram_busy, ram_dout, pix_ready,
      input  frame_done, ram_en, ram_addr, pix_valid, pix_data, pix_eol
   );
endinterface
`default_nettype wire

// File: rtl/vid_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vid_fetch
// Brief    : Linear frame-buffer prefetcher feeding a byte FIFO with EOL tags.
// Revision : 1.0
// ============================================================================
module vid_fetch #(
   parameter logic [14:0] BASE_ADDR      = 15'h0000,
   parameter int          BYTES_PER_LINE = 40,
   parameter int          LINES          = 200,
   parameter int          FIFO_DEPTH     = 8
) (
   input  logic        clk,
   input  logic        reset,
   vid_fetch_if.master bus
);
   localparam int              c_aw        = $clog2(FIFO_DEPTH);
   localparam logic [7:0]      c_col_last  = 8'(BYTES_PER_LINE - 1);
   localparam logic [9:0]      c_line_last = 10'(LINES - 1);
   localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(FIFO_DEPTH);
   localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [14:0]     addr_q, addr_d;
   logic [7:0]      col_q, col_d;
   logic [9:0]      line_q, line_d;
   logic            inflight_q, inflight_d;
   logic            eol_q, eol_d;
   logic            done_q, done_d;
   logic [c_aw-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [c_aw:0]   cnt_q, cnt_d;
   logic [8:0]      mem_q [FIFO_DEPTH];

   logic            w_issue, w_push, w_pop, w_last;
   logic [c_aw:0]   w_occ;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= BASE_ADDR;
         col_q      <= '0;
         line_q     <= '0;
         inflight_q <= 1'b0;
         eol_q      <= 1'b0;
         done_q     <= 1'b0;
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         col_q      <= col_d;
         line_q     <= line_d;
         inflight_q <= inflight_d;
         eol_q      <= eol_d;
         done_q     <= done_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage is cleared on reset so the head reads as zero before any fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (w_push) begin
         mem_q[wr_q] <= {eol_q, bus.ram_dout};
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      col_d      = col_q;
      line_d     = line_q;
      inflight_d = 1'b0;
      eol_d      = eol_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      cnt_d      = cnt_q;
      w_issue    = 1'b0;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_last     = (col_q == c_col_last) && (line_q == c_line_last);
      w_occ      = cnt_q + {{c_aw{1'b0}}, inflight_q};

      if (bus.frame_start) begin
         // Restart wins over everything; the outstanding read is simply never written.
         state_d = S_FETCH;
         addr_d  = BASE_ADDR;
         col_d   = '0;
         line_d  = '0;
         eol_d   = 1'b0;
         rd_d    = '0;
         wr_d    = '0;
         cnt_d   = '0;
      end else begin
         w_issue = (state_q == S_FETCH) && !bus.ram_busy && (w_occ < c_depth);
         w_push  = inflight_q;
         w_pop   = (cnt_q != '0) && bus.pix_ready;

         if (w_issue) begin
            addr_d     = addr_q + 15'd1;
            inflight_d = 1'b1;
            eol_d      = (col_q == c_col_last);
            if (col_q == c_col_last) begin
               col_d  = '0;
               line_d = line_q + 10'd1;
            end else begin
               col_d = col_q + 8'd1;
            end
            if (w_last) begin
               state_d = S_DRAIN;
            end
         end

         if (w_push) wr_d = wr_q + c_ptr_one;
         if (w_pop)  rd_d = rd_q + c_ptr_one;

         case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase

         // Look at next occupancy so frame_done rises right after the final pop.
         if ((state_q == S_DRAIN) && !inflight_q && (cnt_d == '0)) begin
            state_d = S_DONE;
         end
      end

      done_d = (state_d == S_DONE);
   end

   assign bus.ram_en     = w_issue;
   assign bus.ram_addr   = addr_q;
   assign bus.pix_valid  = (cnt_q != '0);
   assign bus.pix_data   = mem_q[rd_q][7:0];
   assign bus.pix_eol    = mem_q[rd_q][8];
   assign bus.frame_done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_vid_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vid_fetch
// Brief    : Directed bench for vid_fetch with a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_vid_fetch;
   localparam int          c_bpl   = 4;
   localparam int          c_lines = 3;
   localparam int          c_depth = 8;
   localparam int          c_n     = c_bpl * c_lines;
   localparam logic [14:0] c_base  = 15'h7FFC;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   vid_fetch_if bus ();

   vid_fetch #(
      .BASE_ADDR      (c_base),
      .BYTES_PER_LINE (c_bpl),
      .LINES          (c_lines),
      .FIFO_DEPTH     (c_depth)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // RAM model: data equals low address byte, garbage when not read.
   always @(posedge clk) begin
      bus.ram_dout <= bus.ram_en ? bus.ram_addr[7:0] : 8'hEE;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          cyc = 0;
   bit          fetching = 0;
   int          issued = 0;
   int          popped = 0;
   int          issue_cyc [c_n];
   logic [8:0]  pop_log [$];
   logic [14:0] addr_log [$];

   always @(negedge clk) begin
      bit          exp_en;
      int          avail;
      logic [14:0] a;
      if (reset) begin
         fetching = 0;
         issued   = 0;
         popped   = 0;
         pop_log.delete();
         addr_log.delete();
      end else begin
         // Unpopped bytes (issued minus popped) are exactly FIFO occupancy plus inflight.
         exp_en = fetching && !bus.ram_busy && !bus.frame_start &&
                  (issued < c_n) && ((issued - popped) < c_depth);
         chk("ram_en", 32'(bus.ram_en), 32'(exp_en));
         if (bus.ram_en && exp_en) begin
            a = 15'(32'(c_base) + issued);
            chk("ram_addr", 32'(bus.ram_addr), 32'(a));
         end
         avail = 0;
         for (int k = 0; k < issued; k++) begin
            if (issue_cyc[k] <= cyc - 2) avail++;
         end
         avail -= popped;
         chk("pix_valid", 32'(bus.pix_valid), 32'(fetching && (avail > 0)));
         chk("frame_done", 32'(bus.frame_done), 32'(fetching && (popped == c_n)));
         if (bus.frame_start) begin
            fetching = 1;
            issued   = 0;
            popped   = 0;
            pop_log.delete();
            addr_log.delete();
         end else begin
            if (bus.pix_valid && bus.pix_ready && (avail > 0) && (popped < c_n)) begin
               a = 15'(32'(c_base) + popped);
               chk("pix_data", 32'(bus.pix_data), 32'(a[7:0]));
               chk("pix_eol", 32'(bus.pix_eol), 32'((popped % c_bpl) == (c_bpl - 1)));
               pop_log.push_back({bus.pix_eol, bus.pix_data});
               popped++;
            end
            if (bus.ram_en && (issued < c_n)) begin
               issue_cyc[issued] = cyc;
               addr_log.push_back(bus.ram_addr);
               issued++;
            end
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_fs();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input bit toggle_busy);
      bit got = 0;
      for (int i = 0; (i < 300) && !got; i++) begin
         @(negedge clk);
         got = bus.frame_done;
         tick();
         if (toggle_busy) bus.ram_busy = ~bus.ram_busy;
      end
      chk(nm, 32'(got), 32'd1);
      bus.ram_busy = 1'b0;
   endtask

   initial begin
      int n_en;
      reset           = 1'b1;
      bus.frame_start = 1'b0;
      bus.ram_busy    = 1'b0;
      bus.pix_ready   = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'h7FFC);
      chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
      chk("rst_pix_data", 32'(bus.pix_data), 32'd0);
      chk("rst_pix_eol", 32'(bus.pix_eol), 32'd0);
      chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
      tick();
      repeat (3) tick();

      // Free-running frame: order, eol tags, address wrap 7FFF -> 0000
      bus.pix_ready = 1'b1;
      pulse_fs();
      wait_done("t1_done", 1'b0);
      chk("t1_count", 32'(pop_log.size()), 32'd12);
      if (pop_log.size() == 12) begin
         chk("t1_first", 32'(pop_log[0]), 32'h0FC);
         chk("t1_eol0", 32'(pop_log[3]), 32'h1FF);
         chk("t1_wrapbyte", 32'(pop_log[4]), 32'h000);
         chk("t1_last", 32'(pop_log[11]), 32'h107);
      end
      chk("t4_addr_n", 32'(addr_log.size()), 32'd12);
      if (addr_log.size() == 12) begin
         chk("t4_a2", 32'(addr_log[2]), 32'h7FFE);
         chk("t4_a3", 32'(addr_log[3]), 32'h7FFF);
         chk("t4_a4", 32'(addr_log[4]), 32'h0000);
         chk("t4_a5", 32'(addr_log[5]), 32'h0001);
      end
      repeat (3) tick();
      chk("t1_done_hold", 32'(bus.frame_done), 32'd1);

      // Back-pressure: credit limit stops issue at FIFO_DEPTH
      bus.pix_ready = 1'b0;
      pulse_fs();
      n_en = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.ram_en) n_en++;
         if (i == 5) chk("t2_head_early", 32'(bus.pix_data), 32'h0FC);
         tick();
      end
      chk("t2_en_pulses", 32'(n_en), 32'd8);
      chk("t2_head_late", 32'(bus.pix_data), 32'h0FC);
      chk("t2_valid", 32'(bus.pix_valid), 32'd1);
      bus.pix_ready = 1'b1;
      wait_done("t2_done", 1'b0);
      chk("t2_count", 32'(pop_log.size()), 32'd12);

      // RAM port shared every other cycle
      bus.ram_busy = 1'b1;
      pulse_fs();
      wait_done("t3_done", 1'b1);
      chk("t3_count", 32'(pop_log.size()), 32'd12);

      // Restart while a read is in flight
      pulse_fs();
      tick();
      tick();
      pulse_fs();
      @(negedge clk);
      chk("t5_empty", 32'(bus.pix_valid), 32'd0);
      chk("t5_addr", 32'(bus.ram_addr), 32'h7FFC);
      chk("t5_fd", 32'(bus.frame_done), 32'd0);
      tick();
      wait_done("t5_done", 1'b0);
      chk("t5_count", 32'(pop_log.size()), 32'd12);
      if (pop_log.size() == 12) chk("t5_first", 32'(pop_log[0]), 32'h0FC);

      // Reset in the middle of a frame
      pulse_fs();
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_ram_en", 32'(bus.ram_en), 32'd0);
      chk("t6_addr", 32'(bus.ram_addr), 32'h7FFC);
      chk("t6_valid", 32'(bus.pix_valid), 32'd0);
      chk("t6_data", 32'(bus.pix_data), 32'd0);
      chk("t6_eol", 32'(bus.pix_eol), 32'd0);
      chk("t6_fd", 32'(bus.frame_done), 32'd0);
      tick();
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
